// File: rtl/shift_sequencer_if.sv
// Command bus between a requester and the shift sequencer; hold exists only when SHIFT_SEQ_HOLD_EN is defined.
interface shift_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] count;
    logic             arith;
`ifdef SHIFT_SEQ_HOLD_EN
    logic             hold;
`endif
    logic             load_n;
    logic             shift;
    logic             asr;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;

`ifdef SHIFT_SEQ_HOLD_EN
    modport master (output start, count, arith, hold,
                    input  load_n, shift, asr, busy, done, remaining);
    modport slave  (input  start, count, arith, hold,
                    output load_n, shift, asr, busy, done, remaining);
`else
    modport master (output start, count, arith,
                    input  load_n, shift, asr, busy, done, remaining);
    modport slave  (input  start, count, arith,
                    output load_n, shift, asr, busy, done, remaining);
`endif
endinterface

// File: rtl/shift_sequencer.sv
// Turns one start request into load, N shifts, done for the 8-bit shifter; all outputs registered.
// Optional SHIFT_SEQ_HOLD_EN adds a hold input that pauses shifting in SHIFT.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    shift_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state, state_nxt;
    logic             load_n_q, shift_q, asr_q, busy_q, done_q;
    logic             load_n_nxt, shift_nxt, asr_nxt, busy_nxt, done_nxt;
    logic [CNT_W-1:0] rem_q, rem_nxt;
    logic             hold_act;

`ifdef SHIFT_SEQ_HOLD_EN
    assign hold_act = bus.hold;
`else
    assign hold_act = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            load_n_q <= 1'b1;
            shift_q  <= 1'b0;
            asr_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rem_q    <= '0;
        end else begin
            state    <= state_nxt;
            load_n_q <= load_n_nxt;
            shift_q  <= shift_nxt;
            asr_q    <= asr_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
            rem_q    <= rem_nxt;
        end
    end

    // SHIFT exits only on an edge where a shift was actually issued with one left.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = LOAD;
            LOAD:    state_nxt = (rem_q == '0) ? DONE : SHIFT;
            SHIFT:   if (shift_q && rem_q == ONE) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_n_nxt = 1'b1;
        shift_nxt  = 1'b0;
        asr_nxt    = asr_q;
        busy_nxt   = (state_nxt != IDLE);
        done_nxt   = 1'b0;
        rem_nxt    = rem_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load_n_nxt = 1'b0;
                    asr_nxt    = bus.arith;
                    rem_nxt    = (bus.count > MAX_CNT) ? MAX_CNT : bus.count;
                end else begin
                    asr_nxt = 1'b0;
                end
            end
            LOAD: begin
                if (state_nxt == DONE) begin
                    done_nxt = 1'b1;
                    rem_nxt  = '0;
                end else begin
                    shift_nxt = 1'b1;
                end
            end
            SHIFT: begin
                if (shift_q) rem_nxt = rem_q - ONE;
                if (state_nxt == DONE) done_nxt = 1'b1;
                else                   shift_nxt = !hold_act;
            end
            DONE: begin
                asr_nxt = 1'b0;
                rem_nxt = '0;
            end
            default: begin
                asr_nxt = 1'b0;
                rem_nxt = '0;
            end
        endcase
    end

    assign bus.load_n    = load_n_q;
    assign bus.shift     = shift_q;
    assign bus.asr       = asr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.remaining = rem_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer; output vector is {load_n, shift, asr, busy, done, remaining}.
module tb_shift_sequencer;
    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    shift_sequencer_if #(.CNT_W(4)) bus ();

    shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [8:0] v(input logic ld_n, input logic sh, input logic as,
                                     input logic bz, input logic dn, input int rem);
        logic [3:0] r;
        r = rem[3:0];
        return {ld_n, sh, as, bz, dn, r};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {bus.load_n, bus.shift, bus.asr, bus.busy, bus.done, bus.remaining};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.count = '0;
        bus.arith = 1'b0;
`ifdef SHIFT_SEQ_HOLD_EN
        bus.hold = 1'b0;
`endif
        step();
        step();
        chk("reset", v(1, 0, 0, 0, 0, 0));
        reset_n = 1'b1;
        step();
        chk("idle_after_reset", v(1, 0, 0, 0, 0, 0));

        // Normal run, count=3 arith=1, with a stray start in cycle 3
        bus.start = 1'b1; bus.count = 4'd3; bus.arith = 1'b1;
        step();
        bus.start = 1'b0; bus.arith = 1'b0;
        chk("run3_c1_load", v(0, 0, 1, 1, 0, 3));
        step(); chk("run3_c2_shift", v(1, 1, 1, 1, 0, 3));
        bus.start = 1'b1; bus.count = 4'd2;
        step(); chk("run3_c3_shift", v(1, 1, 1, 1, 0, 2));
        bus.start = 1'b0;
        step(); chk("run3_c4_shift", v(1, 1, 1, 1, 0, 1));
        step(); chk("run3_c5_done", v(1, 0, 1, 1, 1, 0));
        step(); chk("run3_c6_idle", v(1, 0, 0, 0, 0, 0));
        step(); chk("run3_c7_no_restart", v(1, 0, 0, 0, 0, 0));

        // Zero count, with start held during the done cycle
        bus.start = 1'b1; bus.count = 4'd0; bus.arith = 1'b0;
        step();
        bus.start = 1'b0;
        chk("zero_c1_load", v(0, 0, 0, 1, 0, 0));
        step(); chk("zero_c2_done", v(1, 0, 0, 1, 1, 0));
        bus.start = 1'b1; bus.count = 4'd7; bus.arith = 1'b1;
        step(); chk("zero_c3_idle", v(1, 0, 0, 0, 0, 0));
        bus.start = 1'b0; bus.arith = 1'b0;
        step(); chk("zero_c4_no_restart", v(1, 0, 0, 0, 0, 0));

        // Clamp: count=12 gives 8 shifts
        bus.start = 1'b1; bus.count = 4'd12;
        step();
        bus.start = 1'b0;
        chk("clamp_c1_load", v(0, 0, 0, 1, 0, 8));
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("clamp_c%0d_shift", i + 2), v(1, 1, 0, 1, 0, 8 - i));
        end
        step(); chk("clamp_c10_done", v(1, 0, 0, 1, 1, 0));
        step(); chk("clamp_c11_idle", v(1, 0, 0, 0, 0, 0));

        // Mid-run reset during the second shift cycle
        bus.start = 1'b1; bus.count = 4'd5; bus.arith = 1'b1;
        step();
        bus.start = 1'b0; bus.arith = 1'b0;
        chk("rst_c1_load", v(0, 0, 1, 1, 0, 5));
        step(); chk("rst_c2_shift", v(1, 1, 1, 1, 0, 5));
        step(); chk("rst_c3_shift", v(1, 1, 1, 1, 0, 4));
        reset_n = 1'b0;
        step(); chk("rst_c4_idle", v(1, 0, 0, 0, 0, 0));
        reset_n = 1'b1;
        step(); chk("rst_c5_no_done", v(1, 0, 0, 0, 0, 0));
        step(); chk("rst_c6_no_done", v(1, 0, 0, 0, 0, 0));

`ifdef SHIFT_SEQ_HOLD_EN
        // Hold sampled at the edges opening cycles 3 and 4
        bus.start = 1'b1; bus.count = 4'd4;
        step();
        bus.start = 1'b0;
        chk("hold_c1_load", v(0, 0, 0, 1, 0, 4));
        step(); chk("hold_c2_shift", v(1, 1, 0, 1, 0, 4));
        bus.hold = 1'b1;
        step(); chk("hold_c3_paused", v(1, 0, 0, 1, 0, 3));
        step(); chk("hold_c4_paused", v(1, 0, 0, 1, 0, 3));
        bus.hold = 1'b0;
        step(); chk("hold_c5_shift", v(1, 1, 0, 1, 0, 3));
        step(); chk("hold_c6_shift", v(1, 1, 0, 1, 0, 2));
        step(); chk("hold_c7_shift", v(1, 1, 0, 1, 0, 1));
        step(); chk("hold_c8_done", v(1, 0, 0, 1, 1, 0));
        step(); chk("hold_c9_idle", v(1, 0, 0, 0, 0, 0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
